rvfi_order_serializer: RTL and testbench
========================================

// Module: rvfi_order_serializer
// PURPOSE
//  Scheduler between a core's NRET parallel RVFI retire channels and a single-channel checker/cover port.
//  Captures each retirement into a DEPTH-entry reorder window indexed by rvfi_order.
//  Emits retirements strictly in rvfi_order sequence over one valid/ready stream.
//  Counts emitted instructions and flags protocol violations.
//  Sits between the core wrapper and the formal testbench (checkers, cover counters).
// PARAMETERS
//  NRET       2    retire channels sampled per cycle
//  DEPTH      8    reorder slots; power of 2, >= NRET
//  ORDER_W    8    rvfi_order width; modular sequence number
//  PAYLOAD_W  134  packed rvfi_payload_t (insn, pc_rdata, pc_wdata, rd_addr, rd_wdata, trap)
// PORTS
//  clock        in   1                 single clock, rising edge
//  resetn       in   1                 asynchronous, active-low reset
//  clear        in   1                 synchronous flush, same effect as reset
//  in_valid     in   NRET              per-channel retire strobe; no backpressure
//  in_order     in   NRET*ORDER_W      per-channel rvfi_order
//  in_payload   in   NRET*PAYLOAD_W    per-channel packed payload
//  out_valid    out  1                 serialized retirement available
//  out_ready    in   1                 consumer accepts
//  out_order    out  ORDER_W           order of emitted retirement (== next_order)
//  out_payload  out  PAYLOAD_W         payload of emitted retirement
//  retired_cnt  out  8                 emitted count, saturates at 255
//  err_window   out  1                 sticky: order outside [next_order, next_order+DEPTH)
//  err_overflow out  1                 sticky: target slot already occupied
//  err_dup      out  1                 sticky: two channels same slot in one cycle
// BEHAVIOUR
//  Reset (resetn=0, async) or clear=1 (sync):
//   next_order=0, all slots empty, out_valid=0, retired_cnt=0, all err_*=0.
//  State: occ[DEPTH] valid bits, slot payload/order regs, next_order reg, retired_cnt reg, err flags.
//  Slot index: order[log2(DEPTH)-1:0].
//  Capture, per channel i with in_valid[i]:
//   d = in_order[i] - next_order mod 2^ORDER_W, using pre-edge next_order.
//   d >= DEPTH -> drop, set err_window.
//   Else if occ[slot] set at pre-edge -> drop, set err_overflow. Same-cycle dequeue of the head does not free it for capture.
//   Else if lower-indexed channel targets same slot this cycle -> drop, set err_dup. Lowest index wins.
//   Else write slot, occ<=1.
//  Emit:
//   out_valid = occ[next_order slot]; driven from flops only, no comb path from in_*.
//   out_order/out_payload come from that slot; hold stable while out_valid && !out_ready.
//   Handshake (out_valid && out_ready): clear slot; next_order += 1 (wraps 2^ORDER_W-1 -> 0); retired_cnt += (cnt != 255).
//  Latency: capture at edge N, out_valid at N+1 at earliest. Throughput: 1 emit/cycle.
//  Capture and emit are concurrent in one cycle.
//   A capture can never hit the head slot being freed (d == DEPTH is out of window).
//  Full window + out_ready=0 stalls output indefinitely. New captures then raise err_overflow; state unchanged.
//  Gaps (missing order) stall output; no timeout.
//  Err flags are cleared only by reset/clear.
//  clear has priority over simultaneous capture and emit.
// STRUCTURE
//  rvfi_pkg: rvfi_payload_t packed struct, PAYLOAD_W, ORDER_W, function slot_of(order), function in_window(order, head).
//  Single module; no sub-module needed.
//   Capture loop is a generate over NRET with a priority chain for err_dup.
// TESTING
//  1. Reset; ch0 order 0, then ch0 order 1 on next cycle, out_ready=1
//     -> out_order 0 then 1 on consecutive cycles; retired_cnt=2.
//  2. Same cycle: ch0 order 1, ch1 order 0 -> emits 0 then 1; no errors.
//  3. out_ready=0; fill orders 0..7; then inject order 8
//     -> err_window=1, 8 dropped, out_order stays 0.
//  4. Order 3 captured twice before emit -> err_overflow=1; slot 3 keeps first payload.
//  5. ch0, ch1 both order 2 same cycle -> err_dup=1; ch0 payload emitted.
//  6. Run 300 in-order retirements -> next_order wraps 255->0 cleanly; retired_cnt saturates 255.
//     Then assert resetn=0 mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/rvfi_order_serializer_pkg.sv
// rvfi_order_serializer_pkg: shared widths, payload layout and order/slot helpers
package rvfi_order_serializer_pkg;
  localparam int ORDER_W = 8;
  localparam int DEPTH = 8;
  localparam int SLOT_W = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
  } rvfi_payload_t;
  localparam int PAYLOAD_W = $bits(rvfi_payload_t);
  // Reorder slot selected by the low bits of the order number
  function automatic logic [SLOT_W-1:0] slot_of(input logic [ORDER_W-1:0] order);
    return SLOT_W'(order);
  endfunction
  // True when order lies in [head, head+DEPTH) modulo 2^ORDER_W
  function automatic logic in_window(input logic [ORDER_W-1:0] order, input logic [ORDER_W-1:0] head);
    logic [ORDER_W-1:0] d;
    d = order - head;
    return d < ORDER_W'(DEPTH);
  endfunction
endpackage

// File: rtl/rvfi_order_serializer.sv
// rvfi_order_serializer: reorders parallel RVFI retirements into one in-order valid/ready stream
module rvfi_order_serializer
  import rvfi_order_serializer_pkg::*;
#(
  parameter int NRET = 2
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      clear,
  input  logic [NRET-1:0]           in_valid,
  input  logic [NRET*ORDER_W-1:0]   in_order,
  input  logic [NRET*PAYLOAD_W-1:0] in_payload,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ORDER_W-1:0]        out_order,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [7:0]                retired_cnt,
  output logic                      err_window,
  output logic                      err_overflow,
  output logic                      err_dup
);
  logic [DEPTH-1:0]     occ;
  logic [PAYLOAD_W-1:0] pay [DEPTH];
  logic [ORDER_W-1:0]   next_order;
  logic [SLOT_W-1:0]    head;
  logic [SLOT_W-1:0]    slot [NRET];
  logic [DEPTH-1:0]     claim [NRET];
  logic [NRET-1:0]      win, oob, ovf, dup, wr;
  logic                 fire;
  assign head = slot_of(next_order);
  assign out_valid = occ[head];
  assign out_order = next_order;
  assign out_payload = out_valid ? pay[head] : '0;
  assign fire = out_valid && out_ready;
  assign claim[0] = '0;
  // Per-channel capture decision; claim carries slots taken by lower channels so the lowest index wins
  genvar g;
  for (g = 0; g < NRET; g++) begin : g_cap
    assign slot[g] = slot_of(in_order[g*ORDER_W +: ORDER_W]);
    assign win[g] = in_valid[g] && in_window(in_order[g*ORDER_W +: ORDER_W], next_order);
    assign oob[g] = in_valid[g] && !win[g];
    assign ovf[g] = win[g] && occ[slot[g]];
    assign dup[g] = win[g] && !ovf[g] && claim[g][slot[g]];
    assign wr[g] = win[g] && !ovf[g] && !dup[g];
    if (g < NRET - 1) begin : g_chain
      assign claim[g+1] = claim[g] | (win[g] ? DEPTH'(1) << slot[g] : '0);
    end
  end
  // Occupancy, head pointer, retire counter and sticky error flags
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      occ <= '0;
      next_order <= '0;
      retired_cnt <= '0;
      err_window <= 1'b0;
      err_overflow <= 1'b0;
      err_dup <= 1'b0;
    end else if (clear) begin
      occ <= '0;
      next_order <= '0;
      retired_cnt <= '0;
      err_window <= 1'b0;
      err_overflow <= 1'b0;
      err_dup <= 1'b0;
    end else begin
      if (fire) begin
        occ[head] <= 1'b0;
        next_order <= next_order + 1'b1;
        retired_cnt <= retired_cnt + {7'd0, retired_cnt != 8'hff};
      end
      for (int i = 0; i < NRET; i++)
        if (wr[i]) occ[slot[i]] <= 1'b1;
      err_window <= err_window | (|oob);
      err_overflow <= err_overflow | (|ovf);
      err_dup <= err_dup | (|dup);
    end
  end
  // Payload storage needs no reset: it is only visible through an occupied slot
  always_ff @(posedge clock) begin
    for (int i = 0; i < NRET; i++)
      if (wr[i]) pay[slot[i]] <= in_payload[i*PAYLOAD_W +: PAYLOAD_W];
  end
endmodule

// File: tb/tb_rvfi_order_serializer.sv
// tb_rvfi_order_serializer: directed self-checking bench for the RVFI order serializer
module tb_rvfi_order_serializer;
  import rvfi_order_serializer_pkg::*;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic clear = 1'b0;
  logic out_ready = 1'b0;
  logic [1:0] in_valid = '0;
  logic [2*ORDER_W-1:0] in_order = '0;
  logic [2*PAYLOAD_W-1:0] in_payload = '0;
  logic out_valid;
  logic [ORDER_W-1:0] out_order;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [7:0] retired_cnt;
  logic err_window, err_overflow, err_dup;
  int tests = 0;
  int failed = 0;

  rvfi_order_serializer #(.NRET(2)) dut (
    .clock(clock), .resetn(resetn), .clear(clear),
    .in_valid(in_valid), .in_order(in_order), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_payload(out_payload), .retired_cnt(retired_cnt),
    .err_window(err_window), .err_overflow(err_overflow), .err_dup(err_dup)
  );

  always #5 clock = ~clock;

  function automatic logic [PAYLOAD_W-1:0] pl(input int n);
    return PAYLOAD_W'({n[7:0], 32'hC0DE_0000 + n, 32'hFACE_0000 ^ n, 32'h1234_5678 + n, 32'h9ABC_0000 | n});
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int ch, input logic [ORDER_W-1:0] o, input logic [PAYLOAD_W-1:0] p);
    in_valid[ch] = 1'b1;
    in_order[ch*ORDER_W +: ORDER_W] = o;
    in_payload[ch*PAYLOAD_W +: PAYLOAD_W] = p;
  endtask

  task automatic idle;
    in_valid = '0;
  endtask

  task automatic do_clear;
    idle();
    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (out_order !== 8'd0) begin failed++; $display("FAIL reset_order got %0d exp 0", out_order); end
    tests++; if (retired_cnt !== 8'd0) begin failed++; $display("FAIL reset_cnt got %0d exp 0", retired_cnt); end
    tests++; if ({err_window, err_overflow, err_dup} !== 3'b000) begin failed++; $display("FAIL reset_err got %b exp 000", {err_window, err_overflow, err_dup}); end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_in_order;
    out_ready = 1'b1;
    drive(0, 8'd0, pl(100));
    tick();
    tests++; if (out_valid !== 1'b1 || out_order !== 8'd0) begin failed++; $display("FAIL inorder_first got v=%b o=%0d exp v=1 o=0", out_valid, out_order); end
    tests++; if (out_payload !== pl(100)) begin failed++; $display("FAIL inorder_pay0 got %h exp %h", out_payload, pl(100)); end
    drive(0, 8'd1, pl(101));
    tick();
    tests++; if (out_valid !== 1'b1 || out_order !== 8'd1) begin failed++; $display("FAIL inorder_second got v=%b o=%0d exp v=1 o=1", out_valid, out_order); end
    tests++; if (out_payload !== pl(101)) begin failed++; $display("FAIL inorder_pay1 got %h exp %h", out_payload, pl(101)); end
    idle();
    tick();
    tests++; if (retired_cnt !== 8'd2 || out_valid !== 1'b0) begin failed++; $display("FAIL inorder_cnt got cnt=%0d v=%b exp cnt=2 v=0", retired_cnt, out_valid); end
  endtask

  task automatic test_same_cycle;
    do_clear();
    out_ready = 1'b1;
    drive(0, 8'd1, pl(201));
    drive(1, 8'd0, pl(200));
    tick();
    idle();
    tests++; if (out_valid !== 1'b1 || out_order !== 8'd0 || out_payload !== pl(200)) begin failed++; $display("FAIL same_first got v=%b o=%0d p=%h exp v=1 o=0 p=%h", out_valid, out_order, out_payload, pl(200)); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_order !== 8'd1 || out_payload !== pl(201)) begin failed++; $display("FAIL same_second got v=%b o=%0d p=%h exp v=1 o=1 p=%h", out_valid, out_order, out_payload, pl(201)); end
    tick();
    tests++; if (out_valid !== 1'b0 || retired_cnt !== 8'd2) begin failed++; $display("FAIL same_done got v=%b cnt=%0d exp v=0 cnt=2", out_valid, retired_cnt); end
    tests++; if ({err_window, err_overflow, err_dup} !== 3'b000) begin failed++; $display("FAIL same_err got %b exp 000", {err_window, err_overflow, err_dup}); end
  endtask

  task automatic test_window;
    do_clear();
    for (int k = 0; k < 4; k++) begin
      drive(0, 8'(2*k), pl(300 + 2*k));
      drive(1, 8'(2*k+1), pl(301 + 2*k));
      tick();
    end
    idle();
    drive(0, 8'd8, pl(308));
    tick();
    idle();
    tests++; if (err_window !== 1'b1 || err_overflow !== 1'b0) begin failed++; $display("FAIL window_err got w=%b o=%b exp w=1 o=0", err_window, err_overflow); end
    tests++; if (out_valid !== 1'b1 || out_order !== 8'd0 || out_payload !== pl(300)) begin failed++; $display("FAIL window_hold got v=%b o=%0d exp v=1 o=0", out_valid, out_order); end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    tests++; if (out_valid !== 1'b0 || out_order !== 8'd8 || retired_cnt !== 8'd8) begin failed++; $display("FAIL window_drop got v=%b o=%0d cnt=%0d exp v=0 o=8 cnt=8", out_valid, out_order, retired_cnt); end
  endtask

  task automatic test_overflow;
    do_clear();
    tests++; if (err_window !== 1'b0 || retired_cnt !== 8'd0) begin failed++; $display("FAIL clear_state got w=%b cnt=%0d exp w=0 cnt=0", err_window, retired_cnt); end
    drive(0, 8'd3, pl(403));
    tick();
    drive(0, 8'd3, pl(999));
    tick();
    idle();
    tests++; if (err_overflow !== 1'b1) begin failed++; $display("FAIL ovf_flag got %b exp 1", err_overflow); end
    drive(0, 8'd0, pl(400));
    drive(1, 8'd1, pl(401));
    tick();
    idle();
    drive(0, 8'd2, pl(402));
    tick();
    idle();
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    tests++; if (out_valid !== 1'b1 || out_order !== 8'd3 || out_payload !== pl(403)) begin failed++; $display("FAIL ovf_keep got v=%b o=%0d p=%h exp v=1 o=3 p=%h", out_valid, out_order, out_payload, pl(403)); end
    tests++; if (err_window !== 1'b0 || err_dup !== 1'b0) begin failed++; $display("FAIL ovf_other got w=%b d=%b exp 0 0", err_window, err_dup); end
  endtask

  task automatic test_dup;
    do_clear();
    drive(0, 8'd2, pl(502));
    drive(1, 8'd2, pl(777));
    tick();
    idle();
    tests++; if (err_dup !== 1'b1 || err_overflow !== 1'b0) begin failed++; $display("FAIL dup_flag got d=%b o=%b exp d=1 o=0", err_dup, err_overflow); end
    drive(0, 8'd0, pl(500));
    drive(1, 8'd1, pl(501));
    tick();
    idle();
    out_ready = 1'b1;
    tick();
    tick();
    tests++; if (out_valid !== 1'b1 || out_order !== 8'd2 || out_payload !== pl(502)) begin failed++; $display("FAIL dup_winner got v=%b o=%0d p=%h exp v=1 o=2 p=%h", out_valid, out_order, out_payload, pl(502)); end
  endtask

  task automatic test_wrap_and_reset;
    do_clear();
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      drive(0, 8'(k), pl(k));
      tick();
      tests++; if (out_valid !== 1'b1 || out_order !== 8'(k) || out_payload !== pl(k)) begin failed++; $display("FAIL wrap_step%0d got v=%b o=%0d exp v=1 o=%0d", k, out_valid, out_order, k % 256); end
    end
    idle();
    tick();
    tests++; if (retired_cnt !== 8'd255 || out_valid !== 1'b0 || out_order !== 8'd44) begin failed++; $display("FAIL wrap_end got cnt=%0d v=%b o=%0d exp cnt=255 v=0 o=44", retired_cnt, out_valid, out_order); end
    tests++; if ({err_window, err_overflow, err_dup} !== 3'b000) begin failed++; $display("FAIL wrap_err got %b exp 000", {err_window, err_overflow, err_dup}); end
    out_ready = 1'b0;
    drive(0, 8'd44, pl(44));
    tick();
    idle();
    tests++; if (out_valid !== 1'b1 || out_order !== 8'd44) begin failed++; $display("FAIL stall_hold got v=%b o=%0d exp v=1 o=44", out_valid, out_order); end
    #2;
    resetn = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_order !== 8'd0 || out_payload !== '0 || retired_cnt !== 8'd0) begin failed++; $display("FAIL async_reset got v=%b o=%0d cnt=%0d exp all 0", out_valid, out_order, retired_cnt); end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_same_cycle();
    test_window();
    test_overflow();
    test_dup();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
